// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and segment patterns for the score display
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to seven-segment decoder
// Ports:
//   digit : BCD digit; codes 10..15 decode to a dash
//   blank : 1 forces all segments off
//   seg   : {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import display_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - time-multiplexed common-anode seven-segment scanner
// Ports:
//   CLKT      : system clock, rising edge
//   R         : asynchronous active-low reset
//   DIGITS_IN : packed BCD digits, [3:0] is digit 0 (least significant)
//   LOAD      : snapshot strobe for DIGITS_IN
//   BLANK_LZ  : 1 enables leading-zero blanking
//   SEG       : registered segments {g,f,e,d,c,b,a}, active-low
//   AN        : registered digit enables, one-hot active-low
module bcd_display_scan
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                CLKT,
    input  logic                R,
    input  logic [4*DIGITS-1:0] DIGITS_IN,
    input  logic                LOAD,
    input  logic                BLANK_LZ,
    output logic [6:0]          SEG,
    output logic [DIGITS-1:0]   AN
);

    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [4*DIGITS-1:0] snap;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;

    bcd_t                digit_arr [DIGITS];
    logic [DIGITS-1:0]   lz;
    logic                run_zero;
    bcd_t                cur_digit;
    logic                cur_blank;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            digit_arr[k] = snap[4*k +: 4];
        end
    end

    // lz[k] = digit k and every digit above it are zero. Scanning down from
    // the MSB, any nonzero code (including an illegal one shown as a dash)
    // ends the run of leading zeros.
    always_comb begin
        run_zero = 1'b1;
        lz       = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero = run_zero && (digit_arr[k] == 4'd0);
            lz[k]    = run_zero;
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0".
    always_comb begin
        cur_digit = digit_arr[idx];
        cur_blank = BLANK_LZ && (idx != '0) && lz[idx];
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    always_comb begin
        an_next      = '1;
        an_next[idx] = 1'b0;
    end

    // Outputs are reloaded every cycle from idx/snap, so a load shows on the
    // lit digit one edge after snap changes, without waiting for a tick.
    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            snap <= '0;
            pre  <= '0;
            idx  <= '0;
            AN   <= '1;
            SEG  <= SEG_BLANK;
        end else begin
            if (LOAD) begin
                snap <= DIGITS_IN;
            end
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            AN  <= an_next;
            SEG <= seg_next;
        end
    end

endmodule
